instr_fetch_queue: RTL and testbench
====================================

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the queue entry count (power of two, 2..16).
REQ-002 The block SHALL have parameter RESET_PC, default 8'h00, meaning the first fetch address after reset.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, meaning the synchronous active-high reset.
REQ-005 The block SHALL have port imem_req_valid, output, 1, meaning a fetch request is presented.
REQ-006 The block SHALL have port imem_req_ready, input, 1, meaning the memory accepts the request this cycle.
REQ-007 The block SHALL have port imem_addr, output, 8, meaning the fetch address.
REQ-008 The block SHALL have port imem_rsp_valid, input, 1, meaning response data is valid; responses return in order with latency of 1 cycle or more.
REQ-009 The block SHALL have port imem_rsp_data, input, 16, meaning the instruction word.
REQ-010 The block SHALL have port redirect_valid, input, 1, meaning a flush-and-redirect request.
REQ-011 The block SHALL have port redirect_pc, input, 8, meaning the new fetch address.
REQ-012 The block SHALL have port id_valid, output, 1, meaning the queue head is presented to decode.
REQ-013 The block SHALL have port id_ready, input, 1, meaning decode consumes the head.
REQ-014 The block SHALL have port id_instr, output, 16, meaning the head instruction.
REQ-015 The block SHALL have port id_pc, output, 8, meaning the head instruction address.
REQ-016 The block SHALL have port halted, output, 1, meaning the FSM is in state HALT.

Function
REQ-017 The FSM SHALL have states RUN and HALT; reset enters RUN.
REQ-018 A request SHALL issue when imem_req_valid and imem_req_ready are both high in the same cycle; the fetch PC then increments by 1, mod 256 (wrap 8'hFF to 8'h00).
REQ-019 imem_req_valid SHALL be high only in RUN with (queue count + in-flight count) < DEPTH, with no redirect that cycle, and no halt pending.
REQ-020 Each accepted response SHALL be written to the queue tail with its PC, unless it is marked for discard.
REQ-021 When the queue is non-empty, id_valid SHALL be high and id_instr/id_pc SHALL show the head; the head pops on id_valid and id_ready.
REQ-022 Push and pop in the same cycle SHALL be legal at any fill level, including full and empty.
REQ-023 A write into an empty queue SHALL be visible on id_valid the next cycle; there is no bypass, so minimum response-to-decode latency is 1 cycle.
REQ-024 A response with opcode imem_rsp_data[15:13] = 3'b111 (HALT) SHALL be enqueued, and the FSM SHALL go RUN->HALT.
REQ-025 On the cycle the HALT response arrives, any request issue SHALL be suppressed; later responses still in flight SHALL be discarded.
REQ-026 In HALT, no requests SHALL issue, and the queue SHALL continue draining to decode.
REQ-027 redirect_valid SHALL, next cycle, empty the queue and set the fetch PC to redirect_pc.
REQ-028 redirect_valid SHALL load a drop counter with the in-flight count, minus 1 if a response arrives the same cycle.
REQ-029 redirect_valid SHALL move the FSM to RUN from either state.
REQ-030 While the drop counter is nonzero, responses SHALL be discarded and decrement it.
REQ-031 Redirect SHALL take priority over simultaneous push, pop, issue and halt detection.
REQ-032 The in-flight counter SHALL be wide enough to hold DEPTH, and SHALL never exceed DEPTH.

Reset
REQ-033 Reset SHALL set: FSM=RUN, fetch PC=RESET_PC, queue empty, in-flight=0, drop=0.
REQ-034 Reset SHALL set outputs id_valid=0, halted=0, imem_req_valid=0 (first request the cycle after reset deasserts), id_instr=0, id_pc=0.
REQ-035 Reset mid-operation SHALL discard all state; responses to pre-reset requests are the memory's responsibility (memory is reset alongside).

Structure
REQ-036 A shared package SHALL hold OP_HALT=3'b111, the opcode field position [15:13], and the FSM state enum.
REQ-037 The queue SHALL be a sub-module, sync_fifo, parameterised by width (24 bits: pc+instr) and DEPTH, with full/empty/count outputs.

Verification
REQ-038 Reset, memory always ready, 1-cycle latency, id_ready=1 -> decode sees PC 0,1,2,3... with one instruction per cycle after fill.
REQ-039 id_ready=0 for 10 cycles -> exactly DEPTH=4 requests issued, then imem_req_valid=0; releasing id_ready gives PCs 0..3 in order with no loss.
REQ-040 Redirect to 8'h40 with 2 responses in flight (latency 3) -> both discarded; the next id_pc is 8'h40.
REQ-041 Instruction at PC 5 = 16'hE000 -> PCs 0..5 delivered, halted=1, no further requests; a later redirect to 8'h10 resumes with halted=0.
REQ-042 Start at RESET_PC=8'hFE -> delivered PCs are FE, FF, 00, 01.
REQ-043 Assert reset while the queue is full and 2 requests are in flight -> next cycle id_valid=0, and the first request after reset has imem_addr=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: opcode field, HALT opcode, FSM states.
package instr_fetch_queue_pkg;

   localparam int         OP_MSB  = 15;
   localparam int         OP_LSB  = 13;
   localparam logic [2:0] OP_HALT = 3'b111;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } fsm_state_t;

   function automatic logic is_halt_op(input logic [2:0] op);
      return op == OP_HALT;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; push is accepted when full only if a pop frees a slot the same cycle.
module sync_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   // Storage write; contents need no reset because empty gates visibility.
   always_ff @(posedge clk) begin
      if (do_push && !reset && !flush) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointer and occupancy tracking.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: sequential fetch with bounded outstanding requests,
// HALT opcode detection, and flush-and-redirect with discard of stale responses.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_RUN  | fetching; requests issue while queue + in-flight < DEPTH
// ST_HALT | HALT opcode seen; no requests, late responses dropped, queue drains
module instr_fetch_queue
   import instr_fetch_queue_pkg::*;
#(
   parameter int         DEPTH    = 4,
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [7:0]  imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [15:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [7:0]  redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [15:0] id_instr,
   output logic [7:0]  id_pc,
   output logic        halted
);

   localparam int CW = $clog2(DEPTH) + 1;

   fsm_state_t    state_q, state_d;
   logic [7:0]    pc_q;
   logic [CW-1:0] inflight_q;
   logic [CW-1:0] drop_q;
   logic [CW-1:0] inflight_after_rsp;
   logic [CW-1:0] fifo_count;
   logic [23:0]   fifo_dout;
   logic          fifo_full;
   logic          fifo_empty;
   logic          rsp_discard;
   logic          rsp_accept;
   logic          halt_detect;
   logic          issue;
   logic          push;
   logic          pop;
   logic [7:0]    rsp_pc;

   // Only the current stream's requests remain in flight once drop reaches zero,
   // so the oldest outstanding PC sits inflight_q behind the fetch PC.
   assign rsp_pc      = pc_q - 8'(inflight_q);

   assign rsp_discard = redirect_valid | (drop_q != '0) | (state_q == ST_HALT);
   assign rsp_accept  = imem_rsp_valid & ~rsp_discard;
   assign halt_detect = rsp_accept & is_halt_op(imem_rsp_data[OP_MSB:OP_LSB]);

   assign imem_req_valid = ~reset & (state_q == ST_RUN) & ~redirect_valid & ~halt_detect &
                           (({1'b0, fifo_count} + {1'b0, inflight_q}) < (CW+1)'(DEPTH));
   assign imem_addr      = pc_q;
   assign issue          = imem_req_valid & imem_req_ready;

   assign push     = rsp_accept & (~fifo_full | pop);
   assign pop      = id_valid & id_ready & ~redirect_valid;
   assign id_valid = ~fifo_empty;
   assign id_instr = id_valid ? fifo_dout[15:0]  : 16'h0000;
   assign id_pc    = id_valid ? fifo_dout[23:16] : 8'h00;
   assign halted   = (state_q == ST_HALT);

   assign inflight_after_rsp = (imem_rsp_valid && inflight_q != '0) ? inflight_q - CW'(1) : inflight_q;

   sync_fifo #(
      .WIDTH (24),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (redirect_valid),
      .push  (push),
      .din   ({rsp_pc, imem_rsp_data}),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_RUN;
      else       state_q <= state_d;
   end

   // Next state: redirect always resumes fetching and outranks a HALT in the same cycle.
   always_comb begin
      state_d = state_q;
      if (redirect_valid)   state_d = ST_RUN;
      else if (halt_detect) state_d = ST_HALT;
   end

   // Fetch PC, outstanding-request and stale-response counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q       <= RESET_PC;
         inflight_q <= '0;
         drop_q     <= '0;
      end else begin
         inflight_q <= inflight_after_rsp + CW'(issue);
         if (redirect_valid) begin
            pc_q   <= redirect_pc;
            drop_q <= inflight_after_rsp;
         end else begin
            if (issue) pc_q <= pc_q + 8'd1;
            if (imem_rsp_valid && drop_q != '0) drop_q <= drop_q - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized scoreboard bench: a memory model answers fetches in order with
// programmable latency, and the expected decode stream is derived from the
// program image (sequential PCs until a HALT word, restarting on redirect/reset).
module tb_instr_fetch_queue;

   localparam int         DEPTH  = 4;
   localparam logic [7:0] RST_PC = 8'hFE;

   logic        clk;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [7:0]  imem_addr;
   logic        imem_rsp_valid;
   logic [15:0] imem_rsp_data;
   logic        redirect_valid;
   logic [7:0]  redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [15:0] id_instr;
   logic [7:0]  id_pc;
   logic        halted;

   instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_instr       (id_instr),
      .id_pc          (id_pc),
      .halted         (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  pc;
      logic [15:0] instr;
   } exp_t;

   typedef struct {
      logic [7:0] addr;
      int         due;
   } req_t;

   logic [15:0] mem [256];
   exp_t        exp_q[$];
   req_t        pend[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_due = 0;
   int lat_min = 1;
   int lat_max = 1;
   int rdy_pct = 100;
   int idr_pct = 100;
   int req_count = 0;
   int pop_count = 0;
   int halt_req_count = 0;

   function automatic bit is_halt(input logic [15:0] w);
      return w[15:13] == 3'b111;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected decode stream from a start PC: consecutive addresses up to and including the first HALT word.
   function automatic void load_stream(input logic [7:0] start);
      logic [7:0] p;
      p = start;
      exp_q.delete();
      for (int i = 0; i < 512; i++) begin
         exp_q.push_back('{pc: p, instr: mem[p]});
         if (is_halt(mem[p])) break;
         p = p + 8'd1;
      end
   endfunction

   function automatic void init_mem(input bit with_halts);
      logic [15:0] w;
      int k;
      for (int i = 0; i < 256; i++) begin
         w = 16'($urandom);
         if (is_halt(w)) w[15] = 1'b0;
         mem[i] = w;
      end
      if (with_halts) begin
         for (int j = 0; j < 8; j++) begin
            k = $urandom_range(0, 255);
            mem[k][15:13] = 3'b111;
         end
      end
   endfunction

   // Memory response driver and random handshake knobs.
   initial begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 16'h0;
      imem_req_ready = 1'b0;
      id_ready       = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         cyc++;
         if (!reset && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem[pend[0].addr];
            void'(pend.pop_front());
         end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 16'($urandom);
         end
         imem_req_ready = ($urandom_range(0, 99) < rdy_pct);
         id_ready       = ($urandom_range(0, 99) < idr_pct);
      end
   end

   // Monitor: records issued requests for the memory model and scores decode handshakes.
   always @(negedge clk) begin : monitor
      int   d;
      exp_t e;
      if (reset) begin
         pend.delete();
         last_due = 0;
      end else begin
         if (imem_req_valid && imem_req_ready) begin
            d = cyc + $urandom_range(lat_min, lat_max);
            if (d <= last_due) d = last_due + 1;
            pend.push_back('{addr: imem_addr, due: d});
            last_due = d;
            req_count++;
            if (halted) halt_req_count++;
         end
         if (id_valid && id_ready && !redirect_valid) begin
            pop_count++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_decode: got pc %0h instr %0h expected nothing", id_pc, id_instr);
            end else begin
               e = exp_q.pop_front();
               check("id_pc", 32'(id_pc), 32'(e.pc));
               check("id_instr", 32'(id_instr), 32'(e.instr));
               if (is_halt(e.instr)) check("halted_at_halt_pop", 32'(halted), 32'd1);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      exp_q.delete();
      step(2);
      load_stream(RST_PC);
      req_count      = 0;
      pop_count      = 0;
      halt_req_count = 0;
      reset          = 1'b0;
   endtask

   task automatic do_redirect(input logic [7:0] p);
      @(posedge clk);
      #1;
      redirect_valid = 1'b1;
      redirect_pc    = p;
      load_stream(p);
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
      redirect_pc    = 8'($urandom);
   endtask

   task automatic wait_id_valid(input int budget);
      int n;
      n = 0;
      while (!id_valid && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("id_valid_reached", 32'(id_valid), 32'd1);
   endtask

   task automatic wait_halted(input int budget);
      int n;
      n = 0;
      while (!halted && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("halt_reached", 32'(halted), 32'd1);
   endtask

   initial begin : watchdog
      #400000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : stimulus
      int p0;
      logic [7:0] hpc;
      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 8'h00;

      // Reset values, first request, streaming throughput, PC wrap from FE.
      init_mem(1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_id_valid", 32'(id_valid), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_id_instr", 32'(id_instr), 32'd0);
      check("rst_id_pc", 32'(id_pc), 32'd0);
      @(posedge clk);
      #1;
      load_stream(RST_PC);
      reset = 1'b0;
      @(negedge clk);
      check("first_req_valid", 32'(imem_req_valid), 32'd1);
      check("first_req_addr", 32'(imem_addr), 32'(RST_PC));
      step(10);
      p0 = pop_count;
      step(20);
      check("throughput", 32'(pop_count - p0), 32'd20);

      // Decode stalled: exactly DEPTH requests, then release and drain in order.
      idr_pct = 0;
      apply_reset();
      step(12);
      @(negedge clk);
      check("stall_reqs", 32'(req_count), 32'(DEPTH));
      check("stall_req_valid", 32'(imem_req_valid), 32'd0);
      step(1);
      p0 = pop_count;
      idr_pct = 100;
      step(10);
      check("stall_drain", 32'(pop_count - p0 >= DEPTH), 32'd1);

      // Redirect with two requests in flight at latency 3.
      lat_min = 3;
      lat_max = 3;
      apply_reset();
      step(1);
      do_redirect(8'h40);
      check("redir_inflight", 32'(req_count), 32'd2);
      wait_id_valid(50);
      check("redir_first_pc", 32'(id_pc), 32'h40);
      step(20);

      // HALT word at RESET_PC+5, then redirect resumes.
      lat_min = 1;
      lat_max = 1;
      init_mem(1'b0);
      hpc = RST_PC + 8'd5;
      mem[hpc] = 16'hE000;
      apply_reset();
      wait_halted(60);
      step(20);
      check("halt_all_delivered", 32'(exp_q.size()), 32'd0);
      check("halt_pop_count", 32'(pop_count), 32'd6);
      check("halt_no_reqs", 32'(halt_req_count), 32'd0);
      do_redirect(8'h10);
      @(negedge clk);
      check("resume_halted", 32'(halted), 32'd0);
      p0 = pop_count;
      step(20);
      check("resume_pops", 32'(pop_count - p0 >= 10), 32'd1);

      // Reset while the queue holds entries and requests are outstanding.
      init_mem(1'b0);
      lat_min = 3;
      lat_max = 3;
      idr_pct = 0;
      apply_reset();
      step(6);
      @(negedge clk);
      check("pre_reset_id_valid", 32'(id_valid), 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      check("midrst_id_valid", 32'(id_valid), 32'd0);
      @(posedge clk);
      #1;
      load_stream(RST_PC);
      reset   = 1'b0;
      idr_pct = 100;
      @(negedge clk);
      check("midrst_req_valid", 32'(imem_req_valid), 32'd1);
      check("midrst_req_addr", 32'(imem_addr), 32'(RST_PC));
      step(20);

      // Randomized traffic with HALT words and occasional redirects.
      for (int r = 0; r < 3; r++) begin
         init_mem(1'b1);
         lat_min = 1;
         lat_max = 4;
         rdy_pct = $urandom_range(50, 100);
         idr_pct = $urandom_range(40, 100);
         apply_reset();
         for (int c = 0; c < 400; c++) begin
            step(1);
            if ($urandom_range(0, 39) == 0) do_redirect(8'($urandom));
         end
         check("random_pops_nonzero", 32'(pop_count > 0), 32'd1);
         check("random_no_req_in_halt", 32'(halt_req_count), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
